// File: rtl/tof_pkg.sv
// Shared types and constants for the ToF receive path (cos_sin lookup and I/Q demodulator).
package tof_pkg;

  localparam int unsigned TRIG_W         = 48;
  localparam int unsigned ANGLE_W        = 9;
  localparam int unsigned PERIOD_DEFAULT = 500;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } iq_state_t;

endpackage

// File: rtl/phase_step_ctr.sv
// Modulo-PERIOD angle accumulator: clear forces 0, advance adds STEP and wraps.
module phase_step_ctr
  import tof_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEFAULT,
  parameter int unsigned STEP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [ANGLE_W-1:0] angle
);

  // One extra bit so angle+STEP never overflows before the wrap compare.
  logic [ANGLE_W:0]   sum;
  logic [ANGLE_W-1:0] angle_d;

  always_comb begin
    sum = {1'b0, angle} + (ANGLE_W+1)'(STEP);
    if (sum >= (ANGLE_W+1)'(PERIOD)) begin
      angle_d = ANGLE_W'(sum - (ANGLE_W+1)'(PERIOD));
    end else begin
      angle_d = ANGLE_W'(sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle <= '0;
    end else if (clear) begin
      angle <= '0;
    end else if (advance) begin
      angle <= angle_d;
    end
  end

endmodule

// File: rtl/iq_demod_accum.sv
// I/Q lock-in demodulator: multiplies samples by cos/sin and integrates over a window.
// Define IQ_SAT_EN for saturating accumulation with a sticky sat output.
module iq_demod_accum
  import tof_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned PERIOD     = PERIOD_DEFAULT,
  parameter int unsigned ANGLE_STEP = 1,
  parameter int unsigned WINDOW     = 5000,
  parameter int unsigned ACC_W      = 80
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [ANGLE_W-1:0]  angle,
  input  logic signed [TRIG_W-1:0]   cos_in,
  input  logic signed [TRIG_W-1:0]   sin_in,
  output logic                       busy,
  output logic signed [ACC_W-1:0]    i_sum,
  output logic signed [ACC_W-1:0]    q_sum,
  output logic                       result_valid
`ifdef IQ_SAT_EN
  ,
  output logic                       sat
`endif
);

  localparam int unsigned PROD_W = SAMPLE_W + TRIG_W;
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

  iq_state_t state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       drain_q;
  logic             accept, last, clear;

  logic signed [SAMPLE_W-1:0] s1_sample_q;
  logic                       s1_valid_q;
  logic signed [PROD_W-1:0]   p_i_q, p_q_q;
  logic                       p_valid_q;
  logic signed [ACC_W-1:0]    acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic signed [ACC_W-1:0]    ext_i, ext_q, sum_i, sum_q;

  assign accept = (state_q == RUN) && sample_valid;
  assign last   = accept && (count_q == CNT_W'(WINDOW - 1));
  assign clear  = (state_q == IDLE) && start;
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   if (drain_q == 2'd2) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  phase_step_ctr #(
    .PERIOD (PERIOD),
    .STEP   (ANGLE_STEP)
  ) u_phase_step_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (accept),
    .angle   (angle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      drain_q     <= '0;
      s1_sample_q <= '0;
      s1_valid_q  <= 1'b0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      p_valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + CNT_W'(1);
      end
      drain_q     <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
      s1_sample_q <= sample;
      s1_valid_q  <= accept;
      // cos_in/sin_in now reflect the angle that was presented with s1_sample_q.
      p_i_q       <= s1_sample_q * cos_in;
      p_q_q       <= s1_sample_q * sin_in;
      p_valid_q   <= s1_valid_q;
    end
  end

  assign ext_i = ACC_W'(p_i_q);
  assign ext_q = ACC_W'(p_q_q);
  assign sum_i = acc_i_q + ext_i;
  assign sum_q = acc_q_q + ext_q;

`ifdef IQ_SAT_EN
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf_i, ovf_q, sat_q;

  // Overflow: both operands share a sign that the sum does not.
  assign ovf_i = (acc_i_q[ACC_W-1] == ext_i[ACC_W-1]) && (sum_i[ACC_W-1] != acc_i_q[ACC_W-1]);
  assign ovf_q = (acc_q_q[ACC_W-1] == ext_q[ACC_W-1]) && (sum_q[ACC_W-1] != acc_q_q[ACC_W-1]);

  always_comb begin
    acc_i_d = ovf_i ? (acc_i_q[ACC_W-1] ? AccMin : AccMax) : sum_i;
    acc_q_d = ovf_q ? (acc_q_q[ACC_W-1] ? AccMin : AccMax) : sum_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (clear) begin
      sat_q <= 1'b0;
    end else if (p_valid_q && (ovf_i || ovf_q)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat = sat_q;
`else
  always_comb begin
    acc_i_d = sum_i;
    acc_q_d = sum_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      i_sum        <= '0;
      q_sum        <= '0;
      result_valid <= 1'b0;
    end else begin
      if (clear) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else if (p_valid_q) begin
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
      end
      if (state_q == DONE) begin
        i_sum <= acc_i_q;
        q_sum <= acc_q_q;
      end
      result_valid <= (state_q == DONE);
    end
  end

endmodule
